// File: rtl/axi_pkg.sv
// Shared definitions for the AXI word writer: AXI encodings, FSM states,
// and the AWSIZE helper.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Writer FSM states; IDLE is the reset state and the only non-busy one.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_XFER  = 3'd3,
    ST_RESP  = 3'd4
  } wr_state_t;

  // AXI AxSIZE encoding for a full-width beat: log2 of the beat size in bytes.
  function automatic logic [2:0] awsize_for(input int word_width);
    return 3'($clog2(word_width / 8));
  endfunction

endpackage

// File: rtl/axi_word_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) used between the word writer
// and the DDR-side slave.
interface axi_word_writer_if #(
  parameter int WORD_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [WORD_WIDTH-1:0]   wdata;
  logic [WORD_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_addr_gen.sv
// Next-write-address register for a circular region starting at BASE_ADDR.
// Advances by one beat per strobe and wraps back to BASE_ADDR at the end.
module axi_addr_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    STEP_BYTES   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(STEP_BYTES);
  // Last beat address in the region; the step after it lands on BASE_ADDR.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + REGION_BYTES - STEP;

  // Step forward on each completed write, wrapping inside the region.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr <= BASE_ADDR;
    end else if (advance) begin
      if (next_addr == LAST_ADDR) begin
        next_addr <= BASE_ADDR;
      end else begin
        next_addr <= next_addr + STEP;
      end
    end
  end

endmodule

// File: rtl/axi_word_writer.sv
// Drains packed words from the word FIFO and writes each one to DDR as a
// single-beat AXI4 INCR write, one transaction outstanding at a time.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid is raised without waiting for ready, its payload is held stable while
// valid is high, and valid only drops on the edge that completes the transfer.
module axi_word_writer
  import axi_pkg::*;
#(
  parameter int                    WORD_WIDTH   = 256,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_empty,
  output logic                  word_ren,
  axi_word_writer_if.master     m_axi,
  output logic [31:0]           words_written,
  output logic                  wr_error,
  output logic                  busy,
  output wr_state_t             dbg_state
);

  wr_state_t             state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  advance;

  assign aw_fire = m_axi.awvalid && m_axi.awready;
  assign w_fire  = m_axi.wvalid  && m_axi.wready;
  assign b_fire  = m_axi.bvalid  && m_axi.bready;
  assign advance = (state == ST_RESP) && b_fire;

  // Every beat is a full-width, single-beat INCR burst.
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = awsize_for(WORD_WIDTH);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = 1'b1;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  axi_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .STEP_BYTES   (WORD_WIDTH / 8),
    .BASE_ADDR    (BASE_ADDR),
    .REGION_BYTES (REGION_BYTES)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .next_addr (next_addr)
  );

  // Writer FSM: fetch one word, issue AW and W together, wait for B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      word_ren      <= 1'b0;
      m_axi.awvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.awaddr  <= BASE_ADDR;
      m_axi.wdata   <= '0;
      words_written <= '0;
      wr_error      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // enable is only sampled here so an in-flight write always completes.
          if (enable && !word_empty) begin
            word_ren <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // FIFO read data becomes valid one cycle after the strobe.
          word_ren <= 1'b0;
          state    <= ST_LATCH;
        end
        ST_LATCH: begin
          m_axi.wdata   <= word_data;
          m_axi.awaddr  <= next_addr;
          m_axi.awvalid <= 1'b1;
          m_axi.wvalid  <= 1'b1;
          state         <= ST_XFER;
        end
        ST_XFER: begin
          // AW and W retire independently, in either order or together.
          if (aw_fire) begin
            m_axi.awvalid <= 1'b0;
          end
          if (w_fire) begin
            m_axi.wvalid <= 1'b0;
          end
          if ((aw_fire || !m_axi.awvalid) && (w_fire || !m_axi.wvalid)) begin
            m_axi.bready <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Error responses are recorded but do not stall the stream.
          if (b_fire) begin
            m_axi.bready  <= 1'b0;
            words_written <= words_written + 32'd1;
            if (m_axi.bresp != RESP_OKAY) begin
              wr_error <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_word_writer.md
Name: axi_word_writer

Overview:
- Downstream stage of the byte packer/word FIFO path. Drains packed 256-bit words from the word FIFO and writes each one to DDR as a single-beat AXI4 write.
- Writes go to a linear, wrapping address region.
- Provides status (word count, sticky error, busy) for the rest of the UART-to-DDR datapath.

Parameters:
WORD_WIDTH, 256, data width of the FIFO word and the AXI W channel (power of two, 32..1024)
ADDR_WIDTH, 32, AXI address width
BASE_ADDR, 32'h0000_0000, first byte address written; must be WORD_WIDTH/8 aligned
REGION_BYTES, 32'h0010_0000, size of the circular target region; multiple of WORD_WIDTH/8

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
enable  input  1  when low, no new word is fetched; a transaction in flight completes
word_data  input  WORD_WIDTH  word FIFO read data, valid one cycle after word_ren
word_empty  input  1  word FIFO empty flag
word_ren  output  1  word FIFO read strobe, single-cycle pulse
m_axi_awaddr  output  ADDR_WIDTH  write address
m_axi_awlen  output  8  constant 0
m_axi_awsize  output  3  constant log2(WORD_WIDTH/8)
m_axi_awburst  output  2  constant 2'b01 (INCR)
m_axi_awvalid  output  1  address valid
m_axi_awready  input  1  address ready
m_axi_wdata  output  WORD_WIDTH  write data
m_axi_wstrb  output  WORD_WIDTH/8  constant all ones
m_axi_wlast  output  1  constant 1
m_axi_wvalid  output  1  data valid
m_axi_wready  input  1  data ready
m_axi_bresp  input  2  write response
m_axi_bvalid  input  1  response valid
m_axi_bready  output  1  response ready
words_written  output  32  count of completed B responses, wraps at 2^32
wr_error  output  1  sticky; set on any bresp != 2'b00
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values (async, immediate):
  - state = IDLE
  - word_ren = 0, awvalid = 0, wvalid = 0, bready = 0
  - next address = BASE_ADDR, awaddr = BASE_ADDR, wdata = 0
  - words_written = 0, wr_error = 0, busy = 0
- FSM states: IDLE, FETCH, LATCH, XFER, RESP.
- IDLE: if enable && !word_empty, assert word_ren for exactly one cycle and go to FETCH.
- FETCH: word_ren = 0. FIFO output settles (1-cycle read latency). Go to LATCH.
- LATCH:
  - Register word_data into wdata.
  - Drive awaddr = next address.
  - Go to XFER with awvalid = 1 and wvalid = 1 set on the same edge.
- XFER:
  - awvalid and wvalid are cleared independently on their own handshakes (valid && ready).
  - Either channel may complete first, or both in the same cycle.
  - Payloads stay stable while their valid is high; valid never drops without a handshake.
  - When both handshakes are done, go to RESP with bready = 1.
- RESP:
  - On bvalid && bready:
    - bready = 0
    - words_written += 1
    - if bresp != 0, wr_error = 1
    - next address advances by WORD_WIDTH/8; when it reaches BASE_ADDR + REGION_BYTES it wraps to BASE_ADDR
    - go to IDLE
  - An error response does not stop operation.
- Minimum cycles per word, with all readies high: IDLE→FETCH→LATCH→XFER(1)→RESP(1) = 5 cycles.
- The block never pipelines a second word before the current B response is received. Exactly one outstanding transaction at all times.
- enable deasserted:
  - Checked only in IDLE.
  - Deasserting mid-transaction has no effect until return to IDLE.
- word_empty going high after word_ren has been issued is ignored; the fetched word is still written.
- Reset mid-transaction abandons the transaction:
  - All valids drop immediately.
  - The FIFO word already read is lost; this is accepted.
- wr_error clears only on rst.

Decomposition:
- Shared package (axi_pkg) holds:
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - FSM state encodings
  - clog2-based AWSIZE function
- One sub-module: axi_addr_gen.
  - Holds the next-address register with BASE_ADDR / REGION_BYTES wrap.
  - Advances on an "advance" strobe.
- Everything else stays in axi_word_writer.

Test Plan:
- Single word: preload FIFO with 256'hA5…A5, all readies high → awaddr = 0x0, wdata = A5…A5, wstrb all ones, awlen = 0, awsize = 3'd5, words_written = 1, busy low after 5 cycles.
- Back-to-back: 4 words in FIFO → awaddr 0x00, 0x20, 0x40, 0x60 in order; exactly 4 word_ren pulses; never more than one outstanding AW.
- Channel skew:
  - awready held low 3 cycles after wready handshake → wvalid drops after its handshake, awvalid holds with stable awaddr, RESP entered only after AW handshake.
  - Repeat with W delayed instead.
- Wrap: REGION_BYTES = 0x40, write 3 words → addresses 0x00, 0x20, 0x00.
- Error: bresp = 2'b10 on 2nd of 3 writes → wr_error = 1 from that cycle on, words_written = 3, 3rd write still issued.
- Enable/reset:
  - enable = 0 with non-empty FIFO → no word_ren.
  - rst asserted while in XFER → all valids 0 and counters 0 asynchronously; next transaction restarts at BASE_ADDR.
